// File: rtl/sc_regscroll_driver_if.sv
// Purpose: bundles the control, pattern and strobe signals between game logic, the scroll driver and the 8-bit register.
// Latency: none (wires only).
// Backpressure: none; the downstream register always accepts its clear/load strobes.
//
// Signal summary:
//   SC_REGSCROLL_start_InLow   game -> driver  start request, active low, level-sampled
//   SC_REGSCROLL_stop_InLow    game -> driver  stop request, active low, level-sampled
//   SC_REGSCROLL_dir_In        game -> driver  0 = rotate left, 1 = rotate right
//   SC_REGSCROLL_speed_InBUS   game -> driver  speed level 0..3
//   SC_REGSCROLL_seed_InBUS    game -> driver  initial pattern
//   SC_REGSCROLL_clear_OutLow  driver -> reg   one-cycle clear strobe, active low
//   SC_REGSCROLL_load_OutLow   driver -> reg   one-cycle load strobe, active low
//   SC_REGSCROLL_data_OutBUS   driver -> reg   current pattern
//   SC_REGSCROLL_busy_OutHigh  driver -> game  high while not idle
interface sc_regscroll_driver_if #(
    parameter int REGSCROLL_DATAWIDTH = 8
);
    logic                           SC_REGSCROLL_start_InLow;
    logic                           SC_REGSCROLL_stop_InLow;
    logic                           SC_REGSCROLL_dir_In;
    logic [1:0]                     SC_REGSCROLL_speed_InBUS;
    logic [REGSCROLL_DATAWIDTH-1:0] SC_REGSCROLL_seed_InBUS;
    logic                           SC_REGSCROLL_clear_OutLow;
    logic                           SC_REGSCROLL_load_OutLow;
    logic [REGSCROLL_DATAWIDTH-1:0] SC_REGSCROLL_data_OutBUS;
    logic                           SC_REGSCROLL_busy_OutHigh;

    // Driver side.
    modport master (
        input  SC_REGSCROLL_start_InLow,
        input  SC_REGSCROLL_stop_InLow,
        input  SC_REGSCROLL_dir_In,
        input  SC_REGSCROLL_speed_InBUS,
        input  SC_REGSCROLL_seed_InBUS,
        output SC_REGSCROLL_clear_OutLow,
        output SC_REGSCROLL_load_OutLow,
        output SC_REGSCROLL_data_OutBUS,
        output SC_REGSCROLL_busy_OutHigh
    );

    // Game logic / register side.
    modport slave (
        output SC_REGSCROLL_start_InLow,
        output SC_REGSCROLL_stop_InLow,
        output SC_REGSCROLL_dir_In,
        output SC_REGSCROLL_speed_InBUS,
        output SC_REGSCROLL_seed_InBUS,
        input  SC_REGSCROLL_clear_OutLow,
        input  SC_REGSCROLL_load_OutLow,
        input  SC_REGSCROLL_data_OutBUS,
        input  SC_REGSCROLL_busy_OutHigh
    );
endinterface

// File: rtl/sc_regscroll_driver.sv
// Purpose: rotates an internal pattern one bit every programmable period and strobes it into the downstream register.
// Latency: first load strobe 1 + period + 1 cycles after the start edge; then one load every period + 2 cycles.
// Backpressure: none; strobes are fire-and-forget, stop aborts to IDLE on the next edge.
//
// Ports:
//   SC_REGSCROLL_CLOCK_50      system clock, rising edge
//   SC_REGSCROLL_RESET_InHigh  asynchronous reset, active high
//   bus (master modport)       start/stop/dir/speed/seed in; clear/load/data/busy out
//
// PRESCALE_BASE must be a power of two, >= 8 and < 2**CNTWIDTH.
module sc_regscroll_driver #(
    parameter int REGSCROLL_DATAWIDTH      = 8,
    parameter int REGSCROLL_CNTWIDTH       = 16,
    parameter int REGSCROLL_PRESCALE_BASE  = 4096
) (
    input  logic                  SC_REGSCROLL_CLOCK_50,
    input  logic                  SC_REGSCROLL_RESET_InHigh,
    sc_regscroll_driver_if.master bus
);
    localparam int W = REGSCROLL_DATAWIDTH;
    localparam int C = REGSCROLL_CNTWIDTH;
    localparam logic [C-1:0] BASE_C = REGSCROLL_PRESCALE_BASE[C-1:0];
    localparam logic [C-1:0] ONE_C  = {{(C-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_LOAD  = 3'd4
    } state_t;

    state_t         state_r, state_nxt;
    logic [W-1:0]   pattern_r, pattern_nxt;
    logic [C-1:0]   count_r, count_nxt;
    // Period latched on entry to RUN so a speed change mid-RUN only affects the next RUN.
    logic [C-1:0]   period_r, period_nxt;

    always_ff @(posedge SC_REGSCROLL_CLOCK_50 or posedge SC_REGSCROLL_RESET_InHigh) begin
        if (SC_REGSCROLL_RESET_InHigh) begin
            state_r   <= ST_IDLE;
            pattern_r <= '0;
            count_r   <= '0;
            period_r  <= BASE_C;
        end else begin
            state_r   <= state_nxt;
            pattern_r <= pattern_nxt;
            count_r   <= count_nxt;
            period_r  <= period_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_r;
        pattern_nxt = pattern_r;
        count_nxt   = count_r;
        period_nxt  = period_r;

        if (!bus.SC_REGSCROLL_stop_InLow) begin
            // Stop wins over start and over any pending transition, including the rotate in SHIFT.
            state_nxt = ST_IDLE;
            count_nxt = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    count_nxt = '0;
                    if (!bus.SC_REGSCROLL_start_InLow) begin
                        state_nxt   = ST_CLEAR;
                        pattern_nxt = bus.SC_REGSCROLL_seed_InBUS;
                    end
                end
                ST_CLEAR: begin
                    state_nxt  = ST_RUN;
                    count_nxt  = '0;
                    period_nxt = BASE_C >> bus.SC_REGSCROLL_speed_InBUS;
                end
                ST_RUN: begin
                    if (count_r == period_r - ONE_C) begin
                        state_nxt = ST_SHIFT;
                        count_nxt = '0;
                    end else begin
                        count_nxt = count_r + ONE_C;
                    end
                end
                ST_SHIFT: begin
                    // Rotation lands on the edge into LOAD, so data is already valid for the strobe.
                    state_nxt = ST_LOAD;
                    if (bus.SC_REGSCROLL_dir_In)
                        pattern_nxt = {pattern_r[0], pattern_r[W-1:1]};
                    else
                        pattern_nxt = {pattern_r[W-2:0], pattern_r[W-1]};
                end
                ST_LOAD: begin
                    state_nxt  = ST_RUN;
                    count_nxt  = '0;
                    period_nxt = BASE_C >> bus.SC_REGSCROLL_speed_InBUS;
                end
                default: begin
                    state_nxt = ST_IDLE;
                    count_nxt = '0;
                end
            endcase
        end
    end

    // Strobes decode straight from the state register: glitch-free with respect to inputs,
    // and they release asynchronously the moment reset forces IDLE.
    assign bus.SC_REGSCROLL_clear_OutLow = (state_r != ST_CLEAR);
    assign bus.SC_REGSCROLL_load_OutLow  = (state_r != ST_LOAD);
    assign bus.SC_REGSCROLL_busy_OutHigh = (state_r != ST_IDLE);
    assign bus.SC_REGSCROLL_data_OutBUS  = pattern_r;

endmodule
